// File: rtl/gsm_pkg.sv
// Shared game-state definitions: state encodings and command opcodes.
// The mole-control and display blocks use the same package.
package gsm_pkg;

    typedef enum logic [2:0] {
        GS_READY     = 3'b001,
        GS_PLAYING   = 3'b010,
        GS_OVER      = 3'b011,
        GS_STAGE_CLR = 3'b100,
        GS_GAME_CLR  = 3'b101,
        GS_COUNTDOWN = 3'b110
    } state_t;

    typedef enum logic [2:0] {
        OP_HIT     = 3'd0,
        OP_MISS    = 3'd1,
        OP_PAUSE   = 3'd2,
        OP_RESUME  = 3'd3,
        OP_START   = 3'd4,
        OP_NEXT    = 3'd5,
        OP_RESTART = 3'd7
    } op_t;

    localparam int TIMER_W = 7;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Command port of the game state manager: valid/ready request plus
// one-cycle done/err completion pulses.
interface game_state_ctrl_if;
    import gsm_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    op_t  cmd_op;
    logic done;
    logic err;

    modport master (output cmd_valid, cmd_op, input cmd_ready, done, err);
    modport slave  (input cmd_valid, cmd_op, output cmd_ready, done, err);

endinterface

// File: rtl/gsm_sec_tick.sv
// Second divider: counts 0..TICKS-1 while enabled and flags the terminal
// count. Dropping the enable holds the count so a pause keeps sub-second
// progress; clr restarts it from zero.
module gsm_sec_tick #(
    parameter int TICKS = 1000000
) (
    input  logic clk_1mhz,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == LAST);

    // Advance the count while enabled, wrapping at the terminal count
    always_ff @(posedge clk_1mhz) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game state manager for the mole game: FSM, per-stage countdown timer,
// lives and score, driven through a valid/ready command port.
// Optional build macro GAME_STATE_CTRL_HISCORE_EN keeps a best-score
// register; without it hi_score is tied to zero.
//
// state        | meaning
// READY        | waiting for START, timer preset to the ready length
// COUNTDOWN    | ready countdown running, then play starts automatically
// PLAYING      | stage in progress, HIT/MISS accepted
// OVER         | lives exhausted, only RESTART leaves
// STAGE_CLR    | stage time expired, NEXT goes to READY for the next stage
// GAME_CLR     | last stage expired, only RESTART leaves
module game_state_ctrl
    import gsm_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000000,
    parameter int NUM_STAGES    = 3,
    parameter int MAX_LIVES     = 3,
    parameter int READY_SEC     = 4,
    parameter int PLAY_SEC      = 30,
    parameter int SCORE_W       = 10
) (
    input  logic                              clk_1mhz,
    input  logic                              rst,
    game_state_ctrl_if.slave                  cmd,
    output logic                              sec_tick,
    output logic                              timer_running,
    output logic [TIMER_W-1:0]                timer,
    output logic [2:0]                        state,
    output logic [$clog2(NUM_STAGES+1)-1:0]   stage,
    output logic [$clog2(MAX_LIVES+1)-1:0]    lives,
    output logic [SCORE_W-1:0]                score,
    output logic [SCORE_W-1:0]                hi_score
);
    localparam int SW = $clog2(NUM_STAGES + 1);
    localparam int LW = $clog2(MAX_LIVES + 1);

    localparam logic [2:0] ST_READY     = GS_READY;
    localparam logic [2:0] ST_PLAYING   = GS_PLAYING;
    localparam logic [2:0] ST_OVER      = GS_OVER;
    localparam logic [2:0] ST_STAGE_CLR = GS_STAGE_CLR;
    localparam logic [2:0] ST_GAME_CLR  = GS_GAME_CLR;
    localparam logic [2:0] ST_COUNTDOWN = GS_COUNTDOWN;

    localparam logic [TIMER_W-1:0] T_READY    = TIMER_W'(READY_SEC);
    localparam logic [TIMER_W-1:0] T_PLAY     = TIMER_W'(PLAY_SEC);
    localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);
    localparam logic [SW-1:0]      STAGE_ONE  = SW'(1);
    localparam logic [SW-1:0]      STAGE_LAST = SW'(NUM_STAGES);
    localparam logic [LW-1:0]      LIVES_FULL = LW'(MAX_LIVES);
    localparam logic [LW-1:0]      LIVES_ONE  = LW'(1);

    logic tick;
    logic expire;
    logic accept;
    logic legal;
    logic exec;
    logic restart;
    logic go_over;
    logic go_gclr;
    logic run_state;

    // Divider only runs while there is time left to count down
    gsm_sec_tick #(.TICKS(TICKS_PER_SEC)) u_sec_tick (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .en       (timer_running && (timer != '0)),
        .clr      (restart),
        .tc       (tick)
    );

    // Commands are held off on the expiry edge so a transition never races one
    assign expire        = tick && (timer == T_ONE);
    assign cmd.cmd_ready = !expire;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign exec          = accept && legal;
    assign restart       = exec && (cmd.cmd_op == OP_RESTART);
    assign run_state     = (state == ST_PLAYING) || (state == ST_COUNTDOWN);
    assign go_over       = exec && (cmd.cmd_op == OP_MISS) && (lives == LIVES_ONE);
    assign go_gclr       = expire && (state == ST_PLAYING) && (stage == STAGE_LAST);

    // Decide whether the presented opcode is allowed in the current state
    always_comb begin
        legal = 1'b0;
        case (cmd.cmd_op)
            OP_HIT, OP_MISS: legal = (state == ST_PLAYING);
            OP_PAUSE:        legal = run_state && timer_running;
            OP_RESUME:       legal = run_state && !timer_running;
            OP_START:        legal = (state == ST_READY);
            OP_NEXT:         legal = (state == ST_STAGE_CLR);
            OP_RESTART:      legal = 1'b1;
            default:         legal = 1'b0;
        endcase
    end

    // Game FSM, timer and counters; command effects are applied after the
    // tick so a PAUSE on the terminal count still lets that tick land
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state         <= ST_READY;
            stage         <= STAGE_ONE;
            lives         <= LIVES_FULL;
            score         <= '0;
            timer         <= T_READY;
            timer_running <= 1'b0;
            sec_tick      <= 1'b0;
            cmd.done      <= 1'b0;
            cmd.err       <= 1'b0;
        end else begin
            cmd.done <= exec;
            cmd.err  <= accept && !legal;
            sec_tick <= tick && !restart;
            if (restart) begin
                state         <= ST_READY;
                stage         <= STAGE_ONE;
                lives         <= LIVES_FULL;
                score         <= '0;
                timer         <= T_READY;
                timer_running <= 1'b0;
            end else begin
                if (tick) begin
                    if (expire) begin
                        if (state == ST_COUNTDOWN) begin
                            state <= ST_PLAYING;
                            timer <= T_PLAY;
                        end else begin
                            state         <= go_gclr ? ST_GAME_CLR : ST_STAGE_CLR;
                            stage         <= go_gclr ? stage : stage + 1'b1;
                            timer         <= '0;
                            timer_running <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end else if (timer_running && (timer == '0)) begin
                    timer_running <= 1'b0;
                end
                if (exec) begin
                    case (cmd.cmd_op)
                        OP_HIT: begin
                            if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
                        end
                        OP_MISS: begin
                            if (lives != '0) lives <= lives - 1'b1;
                            if (go_over) begin
                                state         <= ST_OVER;
                                timer_running <= 1'b0;
                            end
                        end
                        OP_PAUSE:  timer_running <= 1'b0;
                        OP_RESUME: timer_running <= 1'b1;
                        OP_START: begin
                            state         <= ST_COUNTDOWN;
                            timer         <= T_READY;
                            timer_running <= 1'b1;
                        end
                        OP_NEXT: begin
                            state <= ST_READY;
                            timer <= T_READY;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef GAME_STATE_CTRL_HISCORE_EN
    // Capture the best score whenever a game ends; survives RESTART
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            hi_score <= '0;
        end else if ((go_over || go_gclr) && (score > hi_score)) begin
            hi_score <= score;
        end
    end
`else
    assign hi_score = '0;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a 10-cycle game second,
// 2 s ready, 3 s play, 2 stages and 2 lives.
`timescale 1ns/1ps
module tb_game_state_ctrl;
    import gsm_pkg::*;

    localparam int E_READY = 1, E_PLAYING = 2, E_OVER = 3;
    localparam int E_STAGE_CLR = 4, E_GAME_CLR = 5, E_COUNTDOWN = 6;
`ifdef GAME_STATE_CTRL_HISCORE_EN
    localparam int HI_EN = 1;
`else
    localparam int HI_EN = 0;
`endif

    logic        clk_1mhz = 1'b0;
    logic        rst;
    logic        sec_tick;
    logic        timer_running;
    logic [6:0]  timer;
    logic [2:0]  state;
    logic [1:0]  stage;
    logic [1:0]  lives;
    logic [9:0]  score;
    logic [9:0]  hi_score;

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;

    game_state_ctrl_if cmd_bus ();

    game_state_ctrl #(
        .TICKS_PER_SEC (10),
        .NUM_STAGES    (2),
        .MAX_LIVES     (2),
        .READY_SEC     (2),
        .PLAY_SEC      (3),
        .SCORE_W       (10)
    ) dut (
        .clk_1mhz      (clk_1mhz),
        .rst           (rst),
        .cmd           (cmd_bus),
        .sec_tick      (sec_tick),
        .timer_running (timer_running),
        .timer         (timer),
        .state         (state),
        .stage         (stage),
        .lives         (lives),
        .score         (score),
        .hi_score      (hi_score)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_1mhz);
        #1;
        if (sec_tick) tick_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input op_t op);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        step();
        cmd_bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        bit found;

        // Reset with a START held on the bus: it must be dropped
        rst = 1'b1;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_START;
        idle(3);
        rst = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        chk("rst_state", int'(state), E_READY);
        chk("rst_stage", int'(stage), 1);
        chk("rst_lives", int'(lives), 2);
        chk("rst_score", int'(score), 0);
        chk("rst_timer", int'(timer), 2);
        chk("rst_running", int'(timer_running), 0);
        chk("rst_done", int'(cmd_bus.done), 0);
        chk("rst_err", int'(cmd_bus.err), 0);
        chk("rst_hi", int'(hi_score), 0);
        chk("rst_ready", int'(cmd_bus.cmd_ready), 1);

        // START, ready countdown into PLAYING
        send(OP_START);
        chk("start_done", int'(cmd_bus.done), 1);
        chk("start_state", int'(state), E_COUNTDOWN);
        chk("start_timer", int'(timer), 2);
        chk("start_running", int'(timer_running), 1);
        tick_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 19) chk("cd_expiry_ready", int'(cmd_bus.cmd_ready), 0);
        end
        chk("cd_state", int'(state), E_PLAYING);
        chk("cd_timer", int'(timer), 3);
        chk("cd_ticks", tick_cnt, 2);
        chk("cd_ready_after", int'(cmd_bus.cmd_ready), 1);

        // Score and lose all lives
        send(OP_HIT); send(OP_HIT); send(OP_HIT);
        chk("hit_score", int'(score), 3);
        send(OP_MISS);
        chk("miss1_lives", int'(lives), 1);
        chk("miss1_state", int'(state), E_PLAYING);
        send(OP_MISS);
        chk("miss2_lives", int'(lives), 0);
        chk("miss2_state", int'(state), E_OVER);
        chk("miss2_running", int'(timer_running), 0);
        chk("miss2_hi", int'(hi_score), HI_EN * 3);
        chk("miss2_timer", int'(timer), 3);

        send(OP_RESTART);
        chk("rs_done", int'(cmd_bus.done), 1);
        chk("rs_state", int'(state), E_READY);
        chk("rs_lives", int'(lives), 2);
        chk("rs_score", int'(score), 0);
        chk("rs_hi", int'(hi_score), HI_EN * 3);

        // HIT in READY is illegal
        send(OP_HIT);
        chk("rdyhit_err", int'(cmd_bus.err), 1);
        chk("rdyhit_done", int'(cmd_bus.done), 0);
        chk("rdyhit_state", int'(state), E_READY);
        chk("rdyhit_score", int'(score), 0);
        chk("rdyhit_timer", int'(timer), 2);

        // Pause at divider count 6 keeps sub-second progress
        send(OP_START);
        idle(6);
        send(OP_PAUSE);
        chk("pause_done", int'(cmd_bus.done), 1);
        chk("pause_running", int'(timer_running), 0);
        tick_cnt = 0;
        idle(50);
        chk("pause_ticks", tick_cnt, 0);
        chk("pause_timer", int'(timer), 2);
        send(OP_RESUME);
        chk("resume_done", int'(cmd_bus.done), 1);
        chk("resume_running", int'(timer_running), 1);
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 8 && !found; i++) begin
            step();
            if (sec_tick) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("resume_to_tick", n, 3);
        chk("resume_timer", int'(timer), 1);
        idle(10);
        chk("p1_state", int'(state), E_PLAYING);
        chk("p1_timer", int'(timer), 3);

        // Stage 1: score, illegal commands, HIT held across expiry
        send(OP_HIT); send(OP_HIT);
        chk("p1_score", int'(score), 2);
        send(OP_NEXT);
        chk("next_err", int'(cmd_bus.err), 1);
        chk("next_state", int'(state), E_PLAYING);
        chk("next_timer", int'(timer), 3);
        send(op_t'(3'd6));
        chk("op6_err", int'(cmd_bus.err), 1);
        chk("op6_done", int'(cmd_bus.done), 0);
        chk("op6_lives", int'(lives), 2);
        chk("op6_score", int'(score), 2);
        idle(25);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_HIT;
        chk("exp_ready", int'(cmd_bus.cmd_ready), 0);
        chk("exp_timer", int'(timer), 1);
        step();
        chk("sclr_state", int'(state), E_STAGE_CLR);
        chk("sclr_stage", int'(stage), 2);
        chk("sclr_timer", int'(timer), 0);
        chk("sclr_running", int'(timer_running), 0);
        chk("sclr_done", int'(cmd_bus.done), 0);
        chk("sclr_err", int'(cmd_bus.err), 0);
        chk("sclr_tick", int'(sec_tick), 1);
        step();
        cmd_bus.cmd_valid = 1'b0;
        chk("late_hit_err", int'(cmd_bus.err), 1);
        chk("late_hit_score", int'(score), 2);

        // Stage 2 through to GAME_CLR
        send(OP_NEXT);
        chk("n2_done", int'(cmd_bus.done), 1);
        chk("n2_state", int'(state), E_READY);
        chk("n2_timer", int'(timer), 2);
        chk("n2_stage", int'(stage), 2);
        chk("n2_score", int'(score), 2);
        send(OP_START);
        idle(20);
        chk("p2_state", int'(state), E_PLAYING);
        send(OP_HIT); send(OP_HIT);
        idle(28);
        chk("gclr_state", int'(state), E_GAME_CLR);
        chk("gclr_score", int'(score), 4);
        chk("gclr_stage", int'(stage), 2);
        chk("gclr_timer", int'(timer), 0);
        chk("gclr_running", int'(timer_running), 0);
        chk("gclr_hi", int'(hi_score), HI_EN * 4);

        send(OP_RESTART);
        chk("rs2_stage", int'(stage), 1);
        chk("rs2_score", int'(score), 0);
        chk("rs2_hi", int'(hi_score), HI_EN * 4);

        // Score saturation while paused
        send(OP_START);
        idle(20);
        send(OP_PAUSE);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_HIT;
        idle(1024);
        cmd_bus.cmd_valid = 1'b0;
        chk("sat_score", int'(score), 1023);
        chk("sat_done", int'(cmd_bus.done), 1);
        chk("sat_state", int'(state), E_PLAYING);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
